// File: rtl/spram_bytewrite.sv
// Single-port RAM with byte-lane write enables, a READ_LATENCY-deep read pipeline
// and a read_first / write_first / no_change collision policy.
module spram_bytewrite #(
    parameter int                    ADDR_WIDTH       = 10,
    parameter int                    DATA_WIDTH       = 64,
    parameter int                    BYTE_WIDTH       = 8,
    parameter int                    MEMORY_SIZE      = 65536,
    parameter int                    READ_LATENCY     = 1,
    parameter string                 WRITE_MODE       = "read_first",
    parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             regce,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [DATA_WIDTH-1:0]            dout
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = MEMORY_SIZE / DATA_WIDTH;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam bit MODE_RF = (WRITE_MODE == "read_first");
    localparam bit MODE_WF = (WRITE_MODE == "write_first");
    localparam bit MODE_NC = (WRITE_MODE == "no_change");

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_lane
            $error("spram_bytewrite: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_err_lat
            $error("spram_bytewrite: READ_LATENCY must be within 1..8");
        end
        if (!(MODE_RF || MODE_WF || MODE_NC)) begin : g_err_mode
            $error("spram_bytewrite: WRITE_MODE must be read_first, write_first or no_change");
        end
        if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_pow2
            $error("spram_bytewrite: MEMORY_SIZE/DATA_WIDTH must be a power of two");
        end
        if (IDX_W > ADDR_WIDTH) begin : g_err_depth
            $error("spram_bytewrite: depth exceeds the address space");
        end
    endgenerate

    // Power-on contents are zero; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_ok;
    logic                  load_s1;

    assign idx      = addr[IDX_W-1:0] & IDX_W'(DEPTH - 1);
    assign old_word = mem[idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Writes are blocked while reset is held; the array itself has no reset.
    assign wr_ok = rst_n & en & (|we);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[idx] <= merged;
        end
    end

    assign rd_word = MODE_WF ? merged : old_word;
    assign load_s1 = en && (!MODE_NC || (we == '0));

    logic [DATA_WIDTH-1:0] pipe [READ_LATENCY];

    // Stage 0 captures the array, middle stages follow en, the last stage follows regce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe[s] <= READ_RESET_VALUE;
            end
        end else begin
            if (load_s1) begin
                pipe[0] <= rd_word;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                if (s == READ_LATENCY - 1) begin
                    if (regce) begin
                        pipe[s] <= pipe[s-1];
                    end
                end else if (en) begin
                    pipe[s] <= pipe[s-1];
                end
            end
        end
    end

    assign dout = pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_spram_bytewrite.sv
// Directed bench: six spram_bytewrite instances share one stimulus stream and are
// checked against hand-computed words for modes, latency, regce, wrap and async reset.
module tb_spram_bytewrite;

    localparam logic [63:0] RV2 = 64'h5A5A_0000_C3C3_0000;
    localparam logic [63:0] W0  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] WA  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] X3  = 64'h1122_3344_AAAA_AAAA;
    localparam logic [63:0] DED = 64'h0000_0000_0000_DEAD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        regce;
    logic [11:0] addr;
    logic [7:0]  we;
    logic [63:0] din;
    logic [63:0] dout_rf, dout_wf, dout_nc, dout_l3, dout_wrap, dout_l2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spram_bytewrite #(.WRITE_MODE("read_first")) u_rf (
        .clk(clk), .rst_n(rst_n), .en(en), .regce(regce), .addr(addr[9:0]),
        .we(we), .din(din), .dout(dout_rf));

    spram_bytewrite #(.WRITE_MODE("write_first")) u_wf (
        .clk(clk), .rst_n(rst_n), .en(en), .regce(regce), .addr(addr[9:0]),
        .we(we), .din(din), .dout(dout_wf));

    spram_bytewrite #(.WRITE_MODE("no_change")) u_nc (
        .clk(clk), .rst_n(rst_n), .en(en), .regce(regce), .addr(addr[9:0]),
        .we(we), .din(din), .dout(dout_nc));

    spram_bytewrite #(.READ_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .en(en), .regce(regce), .addr(addr[9:0]),
        .we(we), .din(din), .dout(dout_l3));

    spram_bytewrite #(.ADDR_WIDTH(12)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .regce(regce), .addr(addr),
        .we(we), .din(din), .dout(dout_wrap));

    spram_bytewrite #(.READ_LATENCY(2), .READ_RESET_VALUE(RV2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .en(en), .regce(regce), .addr(addr[9:0]),
        .we(we), .din(din), .dout(dout_l2));

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        regce = 1'b1;
        addr  = '0;
        we    = '0;
        din   = '0;
        cyc();
        cyc();
        chk_val("rst_rf", dout_rf, 64'h0);
        chk_val("rst_l2", dout_l2, RV2);

        rst_n = 1'b1;
        en    = 1'b1;
        addr  = 12'h005;
        cyc();
        chk_val("init_rd", dout_rf, 64'h0);

        addr = 12'h003; din = W0; we = 8'hFF;
        cyc();
        chk_val("rf_full_wr", dout_rf, 64'h0);
        chk_val("wf_full_wr", dout_wf, W0);

        din = WA; we = 8'h0F;
        cyc();
        chk_val("rf_mode", dout_rf, W0);
        chk_val("wf_mode", dout_wf, X3);
        chk_val("nc_mode", dout_nc, 64'h0);

        we = 8'h00; din = '0;
        cyc();
        chk_val("merge_rf", dout_rf, X3);
        chk_val("merge_wf", dout_wf, X3);
        chk_val("merge_nc", dout_nc, X3);

        addr = 12'h005;
        for (int i = 0; i < 3; i++) cyc();
        chk_val("l3_flush", dout_l3, 64'h0);

        addr = 12'h003;
        cyc();
        chk_val("l3_edge1", dout_l3, 64'h0);
        addr = 12'h005;
        cyc();
        chk_val("l3_edge2", dout_l3, 64'h0);
        cyc();
        chk_val("l3_edge3", dout_l3, X3);
        cyc();
        chk_val("l3_edge4", dout_l3, 64'h0);

        addr = 12'h003;
        cyc();
        addr = 12'h005;
        cyc();
        regce = 1'b0; en = 1'b0;
        cyc();
        chk_val("l3_hold_a", dout_l3, 64'h0);
        cyc();
        chk_val("l3_hold_b", dout_l3, 64'h0);
        regce = 1'b1;
        cyc();
        chk_val("l3_regce", dout_l3, X3);

        en = 1'b1; addr = 12'h005; din = DED; we = 8'hFF;
        cyc();
        addr = 12'h405; we = 8'h00; din = '0;
        cyc();
        chk_val("wrap", dout_wrap, DED);

        addr = 12'h005;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async_l2", dout_l2, RV2);
        chk_val("async_rf", dout_rf, 64'h0);

        din = 64'h0000_0000_0000_BEEF; we = 8'hFF;
        cyc();
        chk_val("l2_in_rst", dout_l2, RV2);

        we = 8'h00; din = '0;
        rst_n = 1'b1;
        cyc();
        chk_val("l2_first_edge", dout_l2, RV2);
        chk_val("rf_no_rst_wr", dout_rf, DED);
        cyc();
        chk_val("l2_after_rst", dout_l2, DED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_bytewrite.md
# spram_bytewrite

Synchronous single-port RAM with per-byte write enables, a configurable read pipeline, and a selectable write-mode policy. It is the behavioural memory primitive behind the CPU's main-memory and cache RAM wrappers. A wrapper passes the word address, byte strobes and write data, and receives read data after a fixed latency. Asynchronous reset clears only the read pipeline; memory contents are preserved.

## Interface
- ADDR_WIDTH, 10, width of `addr` (word address)
- DATA_WIDTH, 64, word width in bits
- BYTE_WIDTH, 8, bits per write-enable lane; DATA_WIDTH must be a multiple of it
- MEMORY_SIZE, 65536, total bits; depth = MEMORY_SIZE/DATA_WIDTH, a power of two ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1, read pipeline depth, legal range 1..8
- WRITE_MODE, "read_first", one of "read_first", "write_first", "no_change"
- READ_RESET_VALUE, 0, DATA_WIDTH value loaded into all pipeline stages on reset
- clk  in  1  clock, all activity on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  port enable; gates reads, writes and non-final pipeline stages
- regce  in  1  output-register clock enable, used only when READ_LATENCY ≥ 2
- addr  in  ADDR_WIDTH  word address
- we  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables, lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- din  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  read data

## Operation
- Array index = addr mod depth. Upper address bits are ignored, so addresses wrap.
- Array initialises to all zeros at time 0. Reset never alters array contents.
- Write: on a rising edge with en=1 and rst_n=1, each lane i with we[i]=1 takes din lane i. Lanes with we[i]=0 keep their old value.
- Read, stage 1, on a rising edge with en=1:
  - read_first: loads the pre-write word at addr.
  - write_first: loads the post-write merged word.
  - no_change: loads the word only if we == 0; otherwise stage 1 holds.
- Stage 1 holds whenever en=0.
- Stages 2..L-1 shift from the previous stage on edges with en=1.
- Final stage L (L ≥ 2) loads from stage L-1 on edges with regce=1; otherwise it holds.
- dout = final stage. For L=1, dout = stage 1.
- While rst_n=0:
  - all stages are forced to READ_RESET_VALUE immediately, without waiting for a clock edge;
  - writes are suppressed.
- Reset release is synchronous to clk: the first active edge is the first edge with rst_n=1.
- Elaboration error if DATA_WIDTH % BYTE_WIDTH ≠ 0, READ_LATENCY is outside 1..8, WRITE_MODE is illegal, or depth exceeds 2^ADDR_WIDTH.

## Timing
- Read latency is READ_LATENCY rising edges, with en=1 throughout and regce=1 at the final edge.
- Example, L=1: addr presented before edge N; dout valid after edge N.
- Back-to-back reads at a new address every cycle are supported; throughput is one word per cycle.
- Write then read of the same address on the next cycle returns the new data. There is no write-to-read hazard.
- Simultaneous read and write in one cycle is a single access at the same addr, resolved per WRITE_MODE.
- dout = READ_RESET_VALUE from reset assertion until the first qualifying read completes the pipeline.
- Reset asserted mid-pipeline: in-flight reads are discarded and dout = READ_RESET_VALUE immediately.

## Test plan
- Reset and init, L=1: hold rst_n=0 → dout=0. Release, read addr 5 → dout=0 after 1 edge.
- Byte write, DATA_WIDTH=64: write addr 3, din=0x1122334455667788, we=0xFF. Then write addr 3, din=0xAAAAAAAAAAAAAAAA, we=0x0F. Read addr 3 → 0x11223344AAAAAAAA.
- Write modes, each mode: with 0x1122334455667788 at addr 3, write din=0xAAAAAAAAAAAAAAAA, we=0x0F in the same cycle as the read. dout next cycle:
  - read_first → 0x1122334455667788;
  - write_first → 0x11223344AAAAAAAA;
  - no_change → previous dout unchanged.
- Latency and regce, L=3: read addr 3 with en=1, regce=1 → data on dout after exactly 3 edges. With regce=0 at the third edge, dout holds its old value until regce=1.
- Wrap-around, depth 1024, ADDR_WIDTH=12: write 0xDEAD to addr 0x005, read addr 0x405 → 0xDEAD.
- Async reset mid-read, L=2: read 0xDEAD in flight, pulse rst_n low between edges.
  - dout = READ_RESET_VALUE immediately.
  - A write attempted during reset is not stored.
  - Memory still returns 0xDEAD after reset is released.
